// File: rtl/ext_mem_bridge.sv
// rtl/ext_mem_bridge.sv - external memory endpoint: boot streamer, load address FIFO, arbitrated stores
package ext_mem_bridge_pkg;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 16;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic c;
  } BTk_t;
endpackage

module ext_mem_bridge
  import ext_mem_bridge_pkg::*;
#(
  parameter int DEPTH         = 1024,
  parameter int BOOT_PRE      = 3,
  parameter int BOOT_LEN      = 5,
  parameter int LD_FIFO_DEPTH = 4,
  parameter bit EXTEND_MEM    = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Host_We,
  input  logic [WIDTH_EXADDR-1:0] I_Host_Addr,
  input  logic [WIDTH_DATA-1:0]   I_Host_Data,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_Busy,
  output logic                    O_Ld_Ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_BOOT_PRE, S_BOOT_DATA, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  FTk_t                    tok, tok_nxt;

  logic [WIDTH_DATA-1:0]   mem [DEPTH];
  logic [AW-1:0]           mem_idx;
  logic                    mem_we;
  logic [WIDTH_DATA-1:0]   mem_wdata;
  logic [WIDTH_DATA-1:0]   mem_rdata;

  logic [WIDTH_EXADDR-1:0] fifo [LD_FIFO_DEPTH];
  logic [FW:0]             wr_ptr, rd_ptr;
  logic                    fifo_empty, fifo_full;
  logic                    push, push_ok, pop, stall;
  logic                    st_nack, ovf, ovf_set;
  logic [WIDTH_EXADDR-1:0] pop_addr;

  // Fields that the bridge never looks at are gathered here on purpose.
  logic unused_sigs;
  assign unused_sigs = ^{I_Ld_BTk.t, I_Ld_BTk.c, I_St_FTk.a, I_St_FTk.r, I_St_FTk.c,
                         I_St_FTk.i, I_Host_Addr[WIDTH_EXADDR-1:AW], I_St_Addr[WIDTH_EXADDR-1:AW]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign pop_addr   = fifo[rd_ptr[FW-1:0]];
  assign mem_rdata  = mem[mem_idx];
  assign stall      = tok.v & I_Ld_BTk.n;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push & (~fifo_full | pop);

  // Next-state, next token and the single memory port arbitration.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tok_nxt   = tok;
    mem_idx   = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    push      = 1'b0;
    pop       = 1'b0;
    st_nack   = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      S_IDLE: begin
        mem_we    = I_Host_We;
        mem_idx   = I_Host_Addr[AW-1:0];
        mem_wdata = I_Host_Data;
        if (I_Boot) begin
          state_nxt = S_BOOT_PRE;
          cnt_nxt   = CW'(1);
          tok_nxt   = '0;
          tok_nxt.v = 1'b1;
          tok_nxt.a = 1'b1;
        end
      end
      S_BOOT_PRE: begin
        st_nack = 1'b1;
        tok_nxt = '0;
        tok_nxt.v = 1'b1;
        if (cnt < CW'(BOOT_PRE)) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          mem_idx   = '0;
          tok_nxt.d = mem_rdata;
          cnt_nxt   = CW'(1);
          state_nxt = S_BOOT_DATA;
        end
      end
      S_BOOT_DATA: begin
        st_nack = 1'b1;
        if (cnt < CW'(BOOT_LEN)) begin
          mem_idx   = cnt[AW-1:0];
          tok_nxt   = '0;
          tok_nxt.v = 1'b1;
          tok_nxt.d = mem_rdata;
          cnt_nxt   = cnt + 1'b1;
        end else begin
          tok_nxt.v = 1'b0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        push    = I_Ld_Req;
        pop     = ~fifo_empty & ~stall;
        ovf_set = push & fifo_full & ~pop;
        st_nack = pop;
        if (pop) begin
          mem_idx   = pop_addr[AW-1:0];
          tok_nxt   = '0;
          tok_nxt.v = 1'b1;
          tok_nxt.d = mem_rdata;
          tok_nxt.i = EXTEND_MEM ? pop_addr : '0;
        end else if (!stall) begin
          tok_nxt.v = 1'b0;
        end
        if (I_St_Req && I_St_FTk.v && !pop) begin
          mem_we    = 1'b1;
          mem_idx   = I_St_Addr[AW-1:0];
          mem_wdata = I_St_FTk.d;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state, output token, FIFO pointers and sticky overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      tok    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tok   <= tok_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set) ovf    <= 1'b1;
    end
  end

  // Memory array keeps its contents across reset; writes are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (mem_we && reset) mem[mem_idx] <= mem_wdata;
  end

  // Load address storage; pointers alone define occupancy.
  always_ff @(posedge clock) begin
    if (push_ok) fifo[wr_ptr[FW-1:0]] <= I_Ld_Addr;
  end

  // Back token only carries nack.
  always_comb begin
    O_St_BTk   = '0;
    O_St_BTk.n = st_nack;
  end

  assign O_Ld_FTk = tok;
  assign O_Ld_Ovf = ovf;
  assign O_Busy   = (state == S_BOOT_PRE) || (state == S_BOOT_DATA) ||
                    ((state == S_RUN) && (!fifo_empty || tok.v));
endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb/tb_ext_mem_bridge.sv - self-checking bench for ext_mem_bridge
module tb_ext_mem_bridge;
  import ext_mem_bridge_pkg::*;

  localparam int BP = 3;
  localparam int BL = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Boot, I_Host_We, I_Ld_Req, I_St_Req;
  logic [15:0] I_Host_Addr, I_Ld_Addr, I_St_Addr;
  logic [31:0] I_Host_Data;
  FTk_t        O_Ld_FTk, I_St_FTk;
  BTk_t        I_Ld_BTk, O_St_BTk;
  logic        O_Busy, O_Ld_Ovf;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [1024];
  logic [15:0] exp_q [$];
  bit          prev_hold, have_prev, prev_stn;
  FTk_t        prev_tok;

  int s3_exp  [10] = '{-1, -1, 1, 1, 1, 1, 2, 3, 4, -1};
  int ovf_exp [14] = '{-1, -1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 4, 5, -1};

  ext_mem_bridge #(
    .DEPTH(1024), .BOOT_PRE(BP), .BOOT_LEN(BL), .LD_FIFO_DEPTH(4), .EXTEND_MEM(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot), .I_Host_We(I_Host_We),
    .I_Host_Addr(I_Host_Addr), .I_Host_Data(I_Host_Data), .I_Ld_Req(I_Ld_Req),
    .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk), .I_Ld_BTk(I_Ld_BTk), .I_St_Req(I_St_Req),
    .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk), .O_St_BTk(O_St_BTk), .O_Busy(O_Busy),
    .O_Ld_Ovf(O_Ld_Ovf)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    I_Boot = 0; I_Host_We = 0; I_Host_Addr = '0; I_Host_Data = '0;
    I_Ld_Req = 0; I_Ld_Addr = '0; I_Ld_BTk = '0;
    I_St_Req = 0; I_St_Addr = '0; I_St_FTk = '0;
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    set_idle();
    I_Host_We = 1; I_Host_Addr = 16'(addr); I_Host_Data = data;
    model_mem[addr % 1024] = data;
    next_cycle();
    set_idle();
  endtask

  // addr < 0 means no token is expected this cycle
  task automatic chk_tok(input string tag, input int addr);
    if (addr < 0) begin
      check_val({tag, "_v"}, 64'(O_Ld_FTk.v), 64'h0);
    end else begin
      check_val({tag, "_v"}, 64'(O_Ld_FTk.v), 64'h1);
      check_val({tag, "_d"}, 64'(O_Ld_FTk.d), 64'(model_mem[addr % 1024]));
      check_val({tag, "_i"}, 64'(O_Ld_FTk.i), 64'(addr));
      check_val({tag, "_arc"}, 64'({O_Ld_FTk.a, O_Ld_FTk.r, O_Ld_FTk.c}), 64'h0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    check_val({tag, "_tok"}, 64'(O_Ld_FTk), 64'h0);
    check_val({tag, "_stbtk"}, 64'(O_St_BTk), 64'h0);
    check_val({tag, "_busy"}, 64'(O_Busy), 64'h0);
    check_val({tag, "_ovf"}, 64'(O_Ld_Ovf), 64'h0);
  endtask

  // Boot with load/store requests held high the whole time; they must be ignored.
  task automatic run_boot(input string tag);
    FTk_t e;
    set_idle();
    I_Boot = 1; I_Ld_Req = 1; I_Ld_Addr = 16'h21;
    I_St_Req = 1; I_St_Addr = 16'h50; I_St_FTk.v = 1; I_St_FTk.d = 32'hDEAD;
    next_cycle();
    I_Boot = 0;
    for (int k = 0; k < BP + BL; k++) begin
      #1;
      e = '0; e.v = 1'b1; e.a = (k == 0);
      if (k >= BP) e.d = model_mem[k - BP];
      check_val($sformatf("%s_tok%0d", tag, k), 64'(O_Ld_FTk), 64'(e));
      check_val({tag, "_busy"}, 64'(O_Busy), 64'h1);
      check_val({tag, "_stn"}, 64'(O_St_BTk.n), 64'h1);
      next_cycle();
    end
    set_idle();
    #1;
    check_val({tag, "_end_v"}, 64'(O_Ld_FTk.v), 64'h0);
    check_val({tag, "_end_busy"}, 64'(O_Busy), 64'h0);
    next_cycle();
  endtask

  task automatic single_load(input string tag, input int addr);
    set_idle(); I_Ld_Req = 1; I_Ld_Addr = 16'(addr);
    #1; chk_tok({tag, "_t0"}, -1); next_cycle();
    set_idle();
    #1; chk_tok({tag, "_t1"}, -1); next_cycle();
    #1; chk_tok({tag, "_t2"}, addr); next_cycle();
    #1; chk_tok({tag, "_t3"}, -1); next_cycle();
  endtask

  // One cycle of free-running traffic checked against the ordered request queue.
  task automatic drive_cycle(input bit ld, input logic [15:0] la, input bit st,
                             input logic [15:0] sa, input logic [31:0] sd, input bit sv, input bit nk);
    FTk_t        tk;
    bit          fresh;
    logic [15:0] a;
    I_Ld_Req = ld; I_Ld_Addr = la; I_Ld_BTk = '0; I_Ld_BTk.n = nk;
    I_St_Req = st; I_St_Addr = sa; I_St_FTk = '0; I_St_FTk.v = sv; I_St_FTk.d = sd;
    #1;
    tk = O_Ld_FTk;
    fresh = tk.v && !prev_hold;
    if (have_prev) check_val("rnd_nack_vs_pop", 64'(prev_stn), 64'(fresh));
    if (prev_hold) begin
      check_val("rnd_hold", 64'(tk), 64'(prev_tok));
    end else if (fresh) begin
      if (exp_q.size() == 0) begin
        check_val("rnd_spurious_v", 64'(tk.v), 64'h0);
      end else begin
        a = exp_q.pop_front();
        check_val("rnd_d", 64'(tk.d), 64'(model_mem[a[9:0]]));
        check_val("rnd_i", 64'(tk.i), 64'(a));
      end
    end
    prev_hold = tk.v && nk;
    prev_tok  = tk;
    prev_stn  = O_St_BTk.n;
    have_prev = 1;
    if (st && sv && !O_St_BTk.n) model_mem[sa[9:0]] = sd;
    if (ld) exp_q.push_back(la);
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int issued;
    set_idle();
    reset = 0;
    repeat (3) next_cycle();
    #1; chk_reset_state("reset");
    reset = 1;
    next_cycle();

    // preload
    host_write(0, 32'h11); host_write(1, 32'h22); host_write(2, 32'h33);
    host_write(3, 32'h44); host_write(4, 32'h55); host_write(5, 32'h66);
    host_write(6, 32'h77); host_write(32'h20, 32'hCAFE); host_write(32'h21, 32'h2121);
    host_write(32'h30, 32'h1234); host_write(32'h40, 32'h4040); host_write(32'h50, 32'h5050);
    for (int k = 0; k < 64; k++) host_write(32'h100 + k, $urandom);
    for (int k = 0; k < 64; k++) host_write(32'h200 + k, $urandom);

    // 1: boot
    run_boot("s1");

    // 2: single load, latency 2
    single_load("s2", 32'h20);

    // 3: four loads with a 3-cycle stall on the first token
    for (int c = 0; c < 10; c++) begin
      set_idle();
      I_Ld_Req = (c < 4); I_Ld_Addr = 16'(c + 1); I_Ld_BTk.n = (c >= 2 && c <= 4);
      #1;
      chk_tok($sformatf("s3_c%0d", c), s3_exp[c]);
      check_val("s3_ovf", 64'(O_Ld_Ovf), 64'h0);
      next_cycle();
    end

    // 3b: six loads under a long stall overflow the FIFO; addr 6 is dropped
    for (int c = 0; c < 14; c++) begin
      set_idle();
      I_Ld_Req = (c < 6); I_Ld_Addr = 16'(c + 1); I_Ld_BTk.n = (c < 8);
      #1;
      chk_tok($sformatf("s3ovf_c%0d", c), ovf_exp[c]);
      check_val($sformatf("s3ovf_flag_c%0d", c), 64'(O_Ld_Ovf), 64'(c >= 6));
      next_cycle();
    end
    repeat (3) next_cycle();
    #1; check_val("s3ovf_sticky", 64'(O_Ld_Ovf), 64'h1);

    // 4: store colliding with a pop is nacked and not written
    set_idle(); I_Ld_Req = 1; I_Ld_Addr = 16'h21; next_cycle();
    set_idle(); I_St_Req = 1; I_St_Addr = 16'h30; I_St_FTk.v = 1; I_St_FTk.d = 32'hBEEF;
    #1; check_val("s4_nack", 64'(O_St_BTk.n), 64'h1); next_cycle();
    set_idle();
    #1; chk_tok("s4_ld21", 32'h21); next_cycle();
    single_load("s4_nowrite", 32'h30);
    set_idle(); I_St_Req = 1; I_St_Addr = 16'h30; I_St_FTk.v = 1; I_St_FTk.d = 32'hBEEF;
    #1; check_val("s4_retry_n", 64'(O_St_BTk.n), 64'h0);
    model_mem[32'h30] = 32'hBEEF;
    next_cycle();
    single_load("s4_written", 32'h30);
    single_load("s4_bootstore", 32'h50);

    // 5: store and load to the same address in the same cycle
    set_idle(); I_St_Req = 1; I_St_Addr = 16'h40; I_St_FTk.v = 1; I_St_FTk.d = 32'h7;
    I_Ld_Req = 1; I_Ld_Addr = 16'h40;
    #1; check_val("s5_n", 64'(O_St_BTk.n), 64'h0);
    model_mem[32'h40] = 32'h7;
    next_cycle();
    set_idle();
    #1; chk_tok("s5_t1", -1); next_cycle();
    #1; chk_tok("s5_t2", 32'h40); next_cycle();

    // 6a: reset during a stalled load with an entry still queued
    set_idle(); I_Ld_Req = 1; I_Ld_Addr = 16'h1; next_cycle();
    I_Ld_Addr = 16'h2; next_cycle();
    set_idle(); I_Ld_BTk.n = 1;
    #1; check_val("s6_stalled_v", 64'(O_Ld_FTk.v), 64'h1);
    reset = 0; next_cycle();
    reset = 1; set_idle();
    #1; chk_reset_state("s6_ld_rst");
    next_cycle();

    // 6b: reset during BOOT_DATA, then a clean reboot
    set_idle(); I_Boot = 1; next_cycle();
    I_Boot = 0;
    repeat (3) next_cycle();
    #1; check_val("s6_mid_boot_d", 64'(O_Ld_FTk.d), 64'(model_mem[0]));
    reset = 0; next_cycle();
    reset = 1;
    #1; chk_reset_state("s6_boot_rst");
    next_cycle();
    run_boot("s6_reboot");
    single_load("s6_fifo_clean", 32'h20);
    #1; chk_tok("s6_fifo_clean_t4", -1);
    next_cycle();

    // randomized traffic: loads in 0x100 region (some with wrapping addresses), stores in 0x200 region
    prev_hold = 0; have_prev = 0; prev_tok = '0; prev_stn = 0;
    for (int c = 0; c < 400; c++) begin
      drive_cycle((exp_q.size() < 4) && ($urandom_range(0, 1) == 1),
                  16'h100 + 16'($urandom_range(0, 63)) + (($urandom_range(0, 3) == 0) ? 16'h400 : 16'h0),
                  $urandom_range(0, 2) == 0, 16'h200 + 16'($urandom_range(0, 63)), $urandom,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) drive_cycle(0, '0, 0, '0, '0, 0, 0);
    check_val("rnd_drained", 64'(exp_q.size()), 64'h0);

    // read back the store region
    issued = 0;
    for (int c = 0; c < 600 && (issued < 64 || exp_q.size() > 0); c++) begin
      if (issued < 64 && exp_q.size() < 4) begin
        drive_cycle(1, 16'h200 + 16'(issued), 0, '0, '0, 0, $urandom_range(0, 3) == 0);
        issued++;
      end else begin
        drive_cycle(0, '0, 0, '0, '0, 0, $urandom_range(0, 3) == 0);
      end
    end
    check_val("readback_issued", 64'(issued), 64'd64);
    check_val("readback_done", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
